// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus select, response FSM state and HRESP encodings
//
// Purpose: types shared by the address decoder and the data-phase response
//          multiplexer, so both sides agree on the SELR encoding.
// Ports:   none (package).

package bus_pkg;

   // Decoder select, registered by the decoder and consumed in the data phase.
   typedef enum logic [1:0] {
      SEL_NONE = 2'b00,
      SEL_4K   = 2'b01,
      SEL_2K1  = 2'b10,
      SEL_2K2  = 2'b11
   } sel_t;

   // Data-phase response FSM states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DFIRST,
      ST_DWAIT,
      ST_ERR1,
      ST_ERR2
   } resp_state_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/bus_resp_mux.sv
// rtl/bus_resp_mux.sv - data-phase response mux, select hold and default slave
//
// Purpose: returns HRDATA/HREADY/HRESP from the slave picked by the decoder's
//          registered SELR, holds that slave across wait states, and answers
//          unmapped accesses with a two-cycle ERROR response (counted).
// Ports:
//   clk            bus clock, rising edge
//   rst            asynchronous active-low reset
//   HTRANS_VALID   master presents a valid address phase
//   SELR           registered decoder select, valid in the data-phase cycle
//   HRDATA_*       slave read data (4K, 2K1, 2K2)
//   HREADYOUT_*    slave ready (1 = data phase completes this cycle)
//   HRDATA         read data to master
//   HREADY         bus ready to master and decoder
//   HRESP          0 OKAY, 1 ERROR
//   ERR_CNT        saturating count of error responses issued

module bus_resp_mux
   import bus_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 HTRANS_VALID,
   input  logic [1:0]           SELR,
   input  logic [DATA_W-1:0]    HRDATA_4K,
   input  logic [DATA_W-1:0]    HRDATA_2K1,
   input  logic [DATA_W-1:0]    HRDATA_2K2,
   input  logic                 HREADYOUT_4K,
   input  logic                 HREADYOUT_2K1,
   input  logic                 HREADYOUT_2K2,
   output logic [DATA_W-1:0]    HRDATA,
   output logic                 HREADY,
   output logic                 HRESP,
   output logic [ERR_CNT_W-1:0] ERR_CNT
);

   resp_state_t          state_q, state_d;
   sel_t                 sel_q, sel_d;
   sel_t                 act_sel;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 err_inc;
   logic                 slv_rdy;
   logic [DATA_W-1:0]    slv_data;

   // SELR tracks HADDR every cycle, so it is only trusted in the first
   // data-phase cycle; wait states use the copy captured then.
   assign act_sel = (state_q == ST_DFIRST) ? sel_t'(SELR) : sel_q;

   always_comb begin
      slv_rdy  = 1'b1;
      slv_data = '0;
      case (act_sel)
         SEL_4K:  begin slv_rdy = HREADYOUT_4K;  slv_data = HRDATA_4K;  end
         SEL_2K1: begin slv_rdy = HREADYOUT_2K1; slv_data = HRDATA_2K1; end
         SEL_2K2: begin slv_rdy = HREADYOUT_2K2; slv_data = HRDATA_2K2; end
         default: begin slv_rdy = 1'b1;          slv_data = '0;         end
      endcase
   end

   // In every branch that tests HTRANS_VALID for acceptance HREADY is 1, so
   // HTRANS_VALID alone stands for "address phase accepted" there.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      HREADY  = 1'b1;
      HRESP   = HRESP_OKAY;
      HRDATA  = '0;
      err_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (HTRANS_VALID) state_d = ST_DFIRST;
         end
         ST_DFIRST, ST_DWAIT: begin
            if (state_q == ST_DFIRST) sel_d = act_sel;
            if (act_sel == SEL_NONE) begin
               // Unmapped: this cycle is the first error cycle.
               HREADY  = 1'b0;
               HRESP   = HRESP_ERROR;
               state_d = ST_ERR2;
            end else begin
               HRDATA = slv_data;
               HREADY = slv_rdy;
               if (!slv_rdy)          state_d = ST_DWAIT;
               else if (HTRANS_VALID) state_d = ST_DFIRST;
               else                   state_d = ST_IDLE;
            end
         end
         ST_ERR1: begin
            HREADY  = 1'b0;
            HRESP   = HRESP_ERROR;
            state_d = ST_ERR2;
         end
         ST_ERR2: begin
            HREADY  = 1'b1;
            HRESP   = HRESP_ERROR;
            err_inc = 1'b1;
            state_d = HTRANS_VALID ? ST_DFIRST : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         sel_q     <= SEL_NONE;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_bus_resp_mux.sv
// tb/tb_bus_resp_mux.sv - scoreboard bench for bus_resp_mux

module tb_bus_resp_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic        htrans_valid;
   logic [1:0]  selr;
   logic [15:0] hrdata_4k, hrdata_2k1, hrdata_2k2;
   logic        hreadyout_4k, hreadyout_2k1, hreadyout_2k2;
   logic [15:0] hrdata;
   logic        hready;
   logic        hresp;
   logic [7:0]  err_cnt;

   typedef struct {
      string       name;
      logic        rdy;
      logic        resp;
      logic [15:0] data;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   bus_resp_mux #(.DATA_W(16), .ERR_CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .HTRANS_VALID  (htrans_valid),
      .SELR          (selr),
      .HRDATA_4K     (hrdata_4k),
      .HRDATA_2K1    (hrdata_2k1),
      .HRDATA_2K2    (hrdata_2k2),
      .HREADYOUT_4K  (hreadyout_4k),
      .HREADYOUT_2K1 (hreadyout_2k1),
      .HREADYOUT_2K2 (hreadyout_2k2),
      .HRDATA        (hrdata),
      .HREADY        (hready),
      .HRESP         (hresp),
      .ERR_CNT       (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic compare(input string n, input logic r, input logic e,
                          input logic [15:0] d, input logic [7:0] c);
      n_checks++;
      if (hready !== r || hresp !== e || hrdata !== d || err_cnt !== c) begin
         n_errors++;
         $display("FAIL %s: got rdy=%0b resp=%0b data=%h cnt=%0d, want rdy=%0b resp=%0b data=%h cnt=%0d",
                  n, hready, hresp, hrdata, err_cnt, r, e, d, c);
      end
   endtask

   // Monitor: every cycle with a pending expectation is checked mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            compare(x.name, x.rdy, x.resp, x.data, x.cnt);
         end
      end
   end

   // Push this cycle's expected outputs, then advance to just after the next edge.
   task automatic exp_step(input string n, input logic r, input logic e,
                           input logic [15:0] d, input logic [7:0] c);
      exp_t x;
      x.name = n; x.rdy = r; x.resp = e; x.data = d; x.cnt = c;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic defaults();
      htrans_valid  = 1'b0;
      selr          = 2'b00;
      hrdata_4k     = 16'hA5A5;
      hrdata_2k1    = 16'h1111;
      hrdata_2k2    = 16'h2222;
      hreadyout_4k  = 1'b1;
      hreadyout_2k1 = 1'b1;
      hreadyout_2k2 = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c;
      rst = 1'b0;
      defaults();
      #2;
      compare("reset_state", 1'b1, 1'b0, 16'h0000, 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single read from 4K slave.
      htrans_valid = 1'b1;
      exp_step("a_idle", 1'b1, 1'b0, 16'h0000, 8'd0);
      htrans_valid = 1'b0; selr = 2'b01;
      exp_step("a_data", 1'b1, 1'b0, 16'hA5A5, 8'd0);
      selr = 2'b00;
      exp_step("a_back_idle", 1'b1, 1'b0, 16'h0000, 8'd0);

      // 2K1 stalls 3 cycles; SELR moves to 2K2 (ready) during the wait.
      htrans_valid = 1'b1;
      exp_step("b_idle", 1'b1, 1'b0, 16'h0000, 8'd0);
      htrans_valid = 1'b0; selr = 2'b10; hreadyout_2k1 = 1'b0;
      exp_step("b_wait1", 1'b0, 1'b0, 16'h1111, 8'd0);
      selr = 2'b11;
      exp_step("b_wait2", 1'b0, 1'b0, 16'h1111, 8'd0);
      exp_step("b_wait3", 1'b0, 1'b0, 16'h1111, 8'd0);
      hreadyout_2k1 = 1'b1; hrdata_2k1 = 16'h3333; hreadyout_2k2 = 1'b0;
      exp_step("b_done", 1'b1, 1'b0, 16'h3333, 8'd0);
      defaults();
      exp_step("b_back_idle", 1'b1, 1'b0, 16'h0000, 8'd0);

      // Back-to-back 4K, 2K2, 2K1.
      htrans_valid = 1'b1;
      exp_step("c_idle", 1'b1, 1'b0, 16'h0000, 8'd0);
      selr = 2'b01;
      exp_step("c_4k", 1'b1, 1'b0, 16'hA5A5, 8'd0);
      selr = 2'b11;
      exp_step("c_2k2", 1'b1, 1'b0, 16'h2222, 8'd0);
      htrans_valid = 1'b0; selr = 2'b10;
      exp_step("c_2k1", 1'b1, 1'b0, 16'h1111, 8'd0);
      selr = 2'b00;
      exp_step("c_back_idle", 1'b1, 1'b0, 16'h0000, 8'd0);

      // Reset asserted while 4K slave stalls.
      htrans_valid = 1'b1;
      exp_step("e_idle", 1'b1, 1'b0, 16'h0000, 8'd0);
      htrans_valid = 1'b0; selr = 2'b01; hreadyout_4k = 1'b0;
      exp_step("e_first", 1'b0, 1'b0, 16'hA5A5, 8'd0);
      exp_step("e_wait", 1'b0, 1'b0, 16'hA5A5, 8'd0);
      #1;
      compare("e_pre_reset", 1'b0, 1'b0, 16'hA5A5, 8'd0);
      rst = 1'b0;
      #1;
      compare("e_async_reset", 1'b1, 1'b0, 16'h0000, 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_step("e_idle_after", 1'b1, 1'b0, 16'h0000, 8'd0);
      defaults();

      // Unmapped access with HTRANS_VALID held; next address taken in cycle 2.
      htrans_valid = 1'b1;
      exp_step("d_idle", 1'b1, 1'b0, 16'h0000, 8'd0);
      selr = 2'b00;
      exp_step("d_err1", 1'b0, 1'b1, 16'h0000, 8'd0);
      exp_step("d_err2", 1'b1, 1'b1, 16'h0000, 8'd0);
      htrans_valid = 1'b0; selr = 2'b01;
      exp_step("d_next", 1'b1, 1'b0, 16'hA5A5, 8'd1);
      selr = 2'b00;
      exp_step("d_back_idle", 1'b1, 1'b0, 16'h0000, 8'd1);

      // 300 consecutive error transfers: counter saturates at 255.
      htrans_valid = 1'b1;
      exp_step("f_idle", 1'b1, 1'b0, 16'h0000, 8'd1);
      for (int k = 0; k < 300; k++) begin
         c = (1 + k > 255) ? 8'd255 : 8'(1 + k);
         exp_step("f_err1", 1'b0, 1'b1, 16'h0000, c);
         htrans_valid = (k < 299);
         exp_step("f_err2", 1'b1, 1'b1, 16'h0000, c);
      end
      for (int k = 0; k < 3; k++)
         exp_step("f_hold", 1'b1, 1'b0, 16'h0000, 8'd255);

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_resp_mux.md
Name: bus_resp_mux

Overview:
- Data-phase response multiplexer sitting directly downstream of the address decoder.
- Consumes the decoder's registered SELR and returns HRDATA/HREADY/HRESP to the master from the 4K slave, 2K slave 1 or 2K slave 2.
- Holds the selected slave across wait states, because SELR follows HADDR every cycle.
- Acts as default slave for unmapped addresses (SELR=00) with a two-cycle error response, and counts errors.

Parameters:
- DATA_W, 16, slave/master read data width.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  bus clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- HTRANS_VALID  in  1  master drives a valid address phase this cycle.
- SELR  in  2  decoder select (00 none, 01 4K, 10 2K1, 11 2K2); registered, valid in the data-phase cycle.
- HRDATA_4K / HRDATA_2K1 / HRDATA_2K2  in  DATA_W each  slave read data.
- HREADYOUT_4K / HREADYOUT_2K1 / HREADYOUT_2K2  in  1 each  slave ready (1 = data phase completes this cycle).
- HRDATA  out  DATA_W  read data to master.
- HREADY  out  1  bus ready to master and decoder-side logic.
- HRESP  out  1  0 OKAY, 1 ERROR.
- ERR_CNT  out  ERR_CNT_W  number of error responses issued, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE, sel_q=00, ERR_CNT=0.
  - Outputs HREADY=1, HRESP=0, HRDATA=0.
  - Reset mid-transfer abandons the transfer immediately; there is no partial response.
- Address phase is accepted at a rising edge where HTRANS_VALID=1 and HREADY=1. The next cycle is a data phase.
- FSM states: IDLE, DFIRST, DWAIT, ERR1, ERR2.
- IDLE:
  - Outputs HREADY=1, HRESP=0, HRDATA=0.
  - Accepted address phase -> DFIRST.
- DFIRST (first data-phase cycle):
  - Active select is SELR, sampled directly. sel_q<=SELR.
  - SELR=00 -> outputs as in ERR1 this same cycle, next state ERR2.
  - SELR!=00:
    - HRDATA = selected slave data; HREADY = selected HREADYOUT; HRESP=0.
    - If HREADY=0 -> DWAIT.
    - If HREADY=1: new accepted address phase -> DFIRST; otherwise -> IDLE.
- DWAIT:
  - Active select is sel_q; SELR is ignored, even if it changes.
  - Output rules are the same as DFIRST.
  - Stays while the selected HREADYOUT=0; leaves exactly as DFIRST does when it is 1.
- ERR1: HREADY=0, HRESP=1, HRDATA=0 -> ERR2 unconditionally. Address phases presented here are not accepted.
- ERR2:
  - HREADY=1, HRESP=1, HRDATA=0.
  - ERR_CNT increments at the end of ERR2; it holds at all-ones (no wrap).
  - Next state: accepted address phase -> DFIRST, else IDLE.
- Back-to-back transfers run with zero bubble: data phase N and address phase N+1 overlap.
- Non-selected slaves' HREADYOUT and HRDATA never affect the outputs.
- All outputs are combinational from state, sel_q/SELR and slave inputs. There is no extra latency beyond the decoder's one-cycle select register.

Decomposition:
- Shared package bus_pkg:
  - Enum sel_t: SEL_NONE=2'b00, SEL_4K=2'b01, SEL_2K1=2'b10, SEL_2K2=2'b11.
  - Enum resp_state_t for the five FSM states.
  - Constants HRESP_OKAY=0, HRESP_ERROR=1.
  - The decoder is to be updated to use sel_t.
- No sub-module. FSM, select hold register and error counter all live in bus_resp_mux.

Test Plan:
- Reset asserted mid-DWAIT (4K slave stalling) -> HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0 immediately, without a clock edge; state IDLE after release.
- Single read, SELR=01, HREADYOUT_4K=1, HRDATA_4K=16'hA5A5 -> HRDATA=16'hA5A5, HREADY=1, HRESP=0 in the first data cycle; IDLE next.
- SELR=10 with HREADYOUT_2K1 low 3 cycles, SELR changed to 11 during the wait -> HREADY=0 for 3 cycles; then HRDATA=HRDATA_2K1 with HREADY=1; 2K2 inputs ignored.
- Back-to-back accesses SELR=01 then 11 then 10, all slaves ready -> three consecutive cycles returning 4K, 2K2, 2K1 data, HREADY=1 throughout.
- Unmapped access SELR=00 with HTRANS_VALID held 1 -> cycle1 HREADY=0/HRESP=1; cycle2 HREADY=1/HRESP=1; the next address is accepted only in cycle2; ERR_CNT=1.
- 300 consecutive error transfers with ERR_CNT_W=8 -> ERR_CNT saturates at 255 and holds.
